// File: rtl/posta_pkg.sv
// Shared defaults and FSM encoding for the posta tile scheduler.
package posta_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = DATA_W_DEF + 6;
  localparam int DIM_W_DEF  = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_t;
endpackage

// File: rtl/posta_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads 0 while empty.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module posta_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; empty gating keeps stale words off dout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/posta_tile_sched.sv
// Walks output tiles in raster order, fetches 4x4 patches, pairs core results with tile coords.
// Latency: patch -> core one register; core result -> out_valid one cycle through the result FIFO.
// Backpressure: fetches stall once DEPTH requests are unpopped at the output; out fields hold while out_ready is low.
module posta_tile_sched
  import posta_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = DATA_W + 6,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_tiles_x,
  input  logic [DIM_W-1:0]     cfg_tiles_y,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [DIM_W:0]       rd_req_x,
  output logic [DIM_W:0]       rd_req_y,
  input  logic                 patch_valid,
  input  logic [DATA_W*16-1:0] patch_flat,
  output logic                 core_valid_in,
  output logic [DATA_W*16-1:0] core_patch_flat,
  input  logic                 core_valid_out,
  input  logic [ACC_W*4-1:0]   core_result_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM_W-1:0]     out_tile_x,
  output logic [DIM_W-1:0]     out_tile_y,
  output logic [ACC_W*4-1:0]   out_data
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CRD_W = 2 * DIM_W;
  localparam int RES_W = CRD_W + 4 * ACC_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sched_state_t     state;
  logic [DIM_W-1:0] tiles_x, tiles_y;
  logic [DIM_W-1:0] cur_x, cur_y;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    pend;

  logic             req_acc, out_pop, last_tile, x_wrap;
  logic             patch_ok, patch_stray, core_ok, core_stray;
  logic [CRD_W-1:0] crd_dout;
  logic             crd_full, crd_empty, res_full, res_empty;
  logic [CW-1:0]    crd_cnt, res_cnt;
  logic [RES_W-1:0] res_dout;
  logic             unused_fifo_status;

  assign req_acc     = rd_req_valid && rd_req_ready;
  assign out_pop     = out_valid && out_ready;
  assign x_wrap      = (cur_x == tiles_x - DIM_W'(1));
  assign last_tile   = x_wrap && (cur_y == tiles_y - DIM_W'(1));
  // pend counts fetches still owed a patch; anything arriving while it is zero is unsolicited.
  assign patch_ok    = patch_valid && (pend != '0);
  assign patch_stray = patch_valid && (pend == '0);
  assign core_ok     = core_valid_out && !crd_empty;
  assign core_stray  = core_valid_out && crd_empty;

  assign rd_req_x   = {cur_x, 1'b0};
  assign rd_req_y   = {cur_y, 1'b0};
  assign out_valid  = !res_empty;
  assign out_tile_x = res_dout[RES_W-1 -: DIM_W];
  assign out_tile_y = res_dout[RES_W-DIM_W-1 -: DIM_W];
  assign out_data   = res_dout[4*ACC_W-1:0];

  assign unused_fifo_status = ^{crd_full, res_full, crd_cnt, res_cnt};

  posta_sync_fifo #(.W(CRD_W), .DEPTH(DEPTH)) u_crd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_acc),
    .din   ({cur_x, cur_y}),
    .pop   (core_ok),
    .dout  (crd_dout),
    .full  (crd_full),
    .empty (crd_empty),
    .count (crd_cnt)
  );

  posta_sync_fifo #(.W(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core_ok),
    .din   ({crd_dout, core_result_flat}),
    .pop   (out_pop),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty),
    .count (res_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      tiles_x         <= '0;
      tiles_y         <= '0;
      cur_x           <= '0;
      cur_y           <= '0;
      occ             <= '0;
      pend            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      rd_req_valid    <= 1'b0;
      core_valid_in   <= 1'b0;
      core_patch_flat <= '0;
    end else begin
      done          <= 1'b0;
      core_valid_in <= patch_ok;
      if (patch_ok) core_patch_flat <= patch_flat;

      case ({req_acc, out_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase

      case ({req_acc, patch_ok})
        2'b10:   pend <= pend + 1'b1;
        2'b01:   pend <= pend - 1'b1;
        default: ;
      endcase

      if (state == S_IDLE && start) err <= 1'b0;
      if (patch_stray || core_stray) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            tiles_x <= cfg_tiles_x;
            tiles_y <= cfg_tiles_y;
            cur_x   <= '0;
            cur_y   <= '0;
            if (cfg_tiles_x == '0 || cfg_tiles_y == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (req_acc) begin
            rd_req_valid <= 1'b0;
            if (last_tile) begin
              state <= S_DRAIN;
            end else if (x_wrap) begin
              cur_x <= '0;
              cur_y <= cur_y + 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end else if (!rd_req_valid && occ < DEPTH_C) begin
            rd_req_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (occ == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cur_x <= '0;
          cur_y <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
